// File: rtl/dma_snd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dma_snd_ctrl
//  Purpose  : Sound DMA sequencer. It walks a word counter from the frame
//             start address to the frame end address, one memory fetch per
//             slot grant, and strobes each fetched word into the sound FIFO.
//             It raises a frame-end pulse and can optionally restart the frame.
//  Ports    : clk32/resb    - clock, asynchronous active-low reset
//             CS/A/RW/DIN   - register window write/read access
//             DOUT          - combinational register read data
//             SREQ          - FIFO not full, gates the memory request
//             DREQ/DACK     - memory slot request / one-cycle grant
//             ADDR          - word address [23:1] of the current fetch
//             SLOAD_N       - active-low FIFO load strobe
//             SINT/SACTIVE  - frame-end pulse / frame playing
//  Config   : DMASND_LOOP_EN - when defined, the control loop bit is writable
//             and a looping frame restarts itself at frame end.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_snd_ctrl (
    input  logic        clk32,
    input  logic        resb,
    input  logic        CS,
    input  logic [5:1]  A,
    input  logic        RW,
    input  logic [7:0]  DIN,
    output logic [15:0] DOUT,
    input  logic        SREQ,
    output logic        DREQ,
    input  logic        DACK,
    output logic [23:1] ADDR,
    output logic        SLOAD_N,
    output logic        SINT,
    output logic        SACTIVE
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ARM  = 3'd1;
    localparam logic [2:0] ST_REQ  = 3'd2;
    localparam logic [2:0] ST_LOAD = 3'd3;
    localparam logic [2:0] ST_FEND = 3'd4;

    logic [2:0]  state_q,    state_d;
    logic        en_q,       en_d;
    logic [23:0] start_q,    start_d;
    logic [23:0] end_q,      end_d;
    logic [23:0] cnt_q,      cnt_d;
    logic [23:0] sh_start_q, sh_start_d;
    logic [23:0] sh_end_q,   sh_end_d;
    logic        loop_w;

    logic        wr_w;
    logic        rd_w;
    logic        wr_ctrl_w;
    logic        abort_w;
    logic [23:0] cnt_inc_w;

    assign wr_w      = CS && !RW;
    assign rd_w      = CS && RW;
    assign wr_ctrl_w = wr_w && (A == 5'd0);
    assign abort_w   = wr_ctrl_w && !DIN[0];
    assign cnt_inc_w = cnt_q + 24'd2;   // natural 24-bit wrap

`ifdef DMASND_LOOP_EN
    logic loop_q, loop_d;

    always_comb begin
        loop_d = loop_q;
        if (wr_ctrl_w) begin
            loop_d = DIN[1];
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            loop_q <= 1'b0;
        end else begin
            loop_q <= loop_d;
        end
    end

    assign loop_w = loop_q;
`else
    assign loop_w = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        start_d    = start_q;
        end_d      = end_q;
        cnt_d      = cnt_q;
        sh_start_d = sh_start_q;
        sh_end_d   = sh_end_q;

        // Register writes; only word addresses are stored, so bit0 stays 0.
        if (wr_w) begin
            case (A)
                5'd0: en_d           = DIN[0];
                5'd1: start_d[23:16] = DIN;
                5'd2: start_d[15:8]  = DIN;
                5'd3: start_d[7:0]   = {DIN[7:1], 1'b0};
                5'd7: end_d[23:16]   = DIN;
                5'd8: end_d[15:8]    = DIN;
                5'd9: end_d[7:0]     = {DIN[7:1], 1'b0};
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl_w && DIN[0]) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // The running frame works only from these shadow copies, so
                // later start/end writes wait for the next ARM.
                cnt_d      = start_q;
                sh_start_d = start_q;
                sh_end_d   = end_q;
                state_d    = (start_q == end_q) ? ST_FEND : ST_REQ;
            end
            ST_REQ: begin
                if (DACK) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = cnt_inc_w;
                state_d = (cnt_inc_w == sh_end_q) ? ST_FEND : ST_REQ;
            end
            ST_FEND: begin
                if (loop_w && (sh_start_q != sh_end_q)) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling wins over everything: no load, no counter step, no restart.
        if (abort_w) begin
            state_d    = ST_IDLE;
            cnt_d      = cnt_q;
            sh_start_d = sh_start_q;
            sh_end_d   = sh_end_q;
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            start_q    <= 24'd0;
            end_q      <= 24'd0;
            cnt_q      <= 24'd0;
            sh_start_q <= 24'd0;
            sh_end_q   <= 24'd0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            start_q    <= start_d;
            end_q      <= end_d;
            cnt_q      <= cnt_d;
            sh_start_q <= sh_start_d;
            sh_end_q   <= sh_end_d;
        end
    end

    always_comb begin
        DOUT = 16'd0;
        if (rd_w) begin
            case (A)
                5'd0: DOUT[7:0] = {6'b0, loop_w, en_q};
                5'd1: DOUT[7:0] = start_q[23:16];
                5'd2: DOUT[7:0] = start_q[15:8];
                5'd3: DOUT[7:0] = start_q[7:0];
                5'd4: DOUT[7:0] = cnt_q[23:16];
                5'd5: DOUT[7:0] = cnt_q[15:8];
                5'd6: DOUT[7:0] = cnt_q[7:0];
                5'd7: DOUT[7:0] = end_q[23:16];
                5'd8: DOUT[7:0] = end_q[15:8];
                5'd9: DOUT[7:0] = end_q[7:0];
                default: ;
            endcase
        end
    end

    // Outputs decode straight from registered state so an asynchronous reset
    // reaches them without waiting for a clock edge.
    assign DREQ    = (state_q == ST_REQ) && SREQ;
    assign ADDR    = cnt_q[23:1];
    assign SLOAD_N = (state_q != ST_LOAD);
    assign SINT    = (state_q == ST_FEND);
    assign SACTIVE = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dma_snd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dma_snd_ctrl
//  Purpose  : Self-checking bench for dma_snd_ctrl. A bus model grants
//             requests, a monitor logs every FIFO load address and frame-end
//             pulse, and a frame model lists the expected event sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_snd_ctrl;

    logic        clk32;
    logic        resb;
    logic        CS;
    logic [4:0]  A_s;
    logic        RW;
    logic [7:0]  DIN;
    logic [15:0] DOUT;
    logic        SREQ;
    logic        DREQ;
    logic        DACK;
    logic [22:0] ADDR;
    logic        SLOAD_N;
    logic        SINT;
    logic        SACTIVE;

    dma_snd_ctrl dut (
        .clk32   (clk32),
        .resb    (resb),
        .CS      (CS),
        .A       (A_s),
        .RW      (RW),
        .DIN     (DIN),
        .DOUT    (DOUT),
        .SREQ    (SREQ),
        .DREQ    (DREQ),
        .DACK    (DACK),
        .ADDR    (ADDR),
        .SLOAD_N (SLOAD_N),
        .SINT    (SINT),
        .SACTIVE (SACTIVE)
    );

    localparam logic [31:0] EV_SINT = 32'h8000_0000;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] ev_q[$];
    logic [31:0] exp_q[$];
    bit          sreq_rand  = 1'b0;
    bit          sreq_force = 1'b0;
    bit          dack_en    = 1'b1;
    int          dack_delay = 3;
    int          wcnt       = 0;

    logic [15:0] rd;
    logic [23:0] v, s, e;
    int          n, bad, k;

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame model: one fetch per word from start up to (not including) end,
    // wrapping in the 24-bit space, followed by a single frame-end pulse.
    task automatic model_frame(input logic [23:0] fs, input logic [23:0] fe);
        logic [23:0] a;
        a = fs;
        while (a != fe) begin
            exp_q.push_back({9'b0, a[23:1]});
            a = a + 24'd2;
        end
        exp_q.push_back(EV_SINT);
    endtask

    task automatic cmp_events(input string tag);
        chk($sformatf("%s_count", tag), ev_q.size(), exp_q.size());
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
        end
    endtask

    task automatic reg_write(input logic [4:0] idx, input logic [7:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b0; A_s = idx; DIN = d;
        @(posedge clk32);
        #1;
        CS = 1'b0; RW = 1'b1;
    endtask

    task automatic reg_read(input logic [4:0] idx, output logic [15:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b1; A_s = idx;
        #1;
        d  = DOUT;
        CS = 1'b0;
    endtask

    task automatic write24(input logic [4:0] base, input logic [23:0] val);
        reg_write(base,        val[23:16]);
        reg_write(base + 5'd1, val[15:8]);
        reg_write(base + 5'd2, val[7:0]);
    endtask

    task automatic read24(input logic [4:0] base, output logic [23:0] val);
        logic [15:0] h, m, l;
        reg_read(base,        h);
        reg_read(base + 5'd1, m);
        reg_read(base + 5'd2, l);
        val = {h[7:0], m[7:0], l[7:0]};
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c;
        c = 0;
        while (SACTIVE !== 1'b0 && c < maxc) begin
            @(negedge clk32);
            #2;
            c++;
        end
        chk(tag, SACTIVE, 1'b0);
    endtask

    // Event monitor
    initial begin
        forever begin
            @(negedge clk32);
            #1;
            if (resb === 1'b1) begin
                if (SLOAD_N === 1'b0) ev_q.push_back({9'b0, ADDR});
                if (SINT === 1'b1)    ev_q.push_back(EV_SINT);
            end
        end
    end

    // FIFO and bus arbiter model
    initial begin
        forever begin
            @(negedge clk32);
            SREQ = sreq_rand ? ($urandom_range(0, 3) != 0) : sreq_force;
            #1;
            if (dack_en) begin
                DACK = 1'b0;
                if (DREQ === 1'b1) begin
                    if (wcnt >= dack_delay) begin
                        DACK = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        CS = 1'b0; RW = 1'b1; A_s = 5'd0; DIN = 8'd0; DACK = 1'b0; SREQ = 1'b0;
        resb = 1'b1;
        #1 resb = 1'b0;
        #2;
        chk("rst_dreq",    DREQ,    1'b0);
        chk("rst_sload_n", SLOAD_N, 1'b1);
        chk("rst_sint",    SINT,    1'b0);
        chk("rst_sactive", SACTIVE, 1'b0);
        chk("rst_addr",    ADDR,    23'd0);
        repeat (3) @(negedge clk32);
        resb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            reg_read(5'(i), rd);
            chk($sformatf("rst_reg%0d", i), rd, 16'd0);
        end

        // Single frame, fixed grant latency
        sreq_force = 1'b1; dack_delay = 3;
        write24(5'd1, 24'h010000);
        write24(5'd7, 24'h010006);
        reg_read(5'd3, rd);
        chk("start_lo_read", rd, 16'h0000);
        reg_read(5'd9, rd);
        chk("end_lo_read", rd, 16'h0006);
        reg_read(5'd12, rd);
        chk("unmapped_read", rd, 16'h0000);
        ev_q.delete(); exp_q.delete();
        model_frame(24'h010000, 24'h010006);
        reg_write(5'd0, 8'h01);
        wait_idle("single_idle", 200);
        cmp_events("single");
        reg_read(5'd0, rd);
        chk("single_ctrl", rd, 16'h0000);
        read24(5'd4, v);
        chk("single_cnt", v, 24'h010006);

        // FIFO backpressure
        sreq_force = 1'b0;
        write24(5'd1, 24'h000300);
        write24(5'd7, 24'h000304);
        ev_q.delete(); exp_q.delete();
        model_frame(24'h000300, 24'h000304);
        reg_write(5'd0, 8'h01);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk32);
            #2;
            if (DREQ !== 1'b0 || SLOAD_N !== 1'b1) bad++;
        end
        chk("bp_quiet", bad, 0);
        sreq_force = 1'b1;
        @(negedge clk32);
        #2;
        chk("bp_dreq_rise", DREQ, 1'b1);
        wait_idle("bp_idle", 200);
        cmp_events("bp");

        // Loop with mid-frame end update
        write24(5'd1, 24'h000020);
        write24(5'd7, 24'h000024);
        ev_q.delete(); exp_q.delete();
        model_frame(24'h000020, 24'h000024);
`ifdef DMASND_LOOP_EN
        model_frame(24'h000020, 24'h000028);
`endif
        reg_write(5'd0, 8'h03);
        reg_read(5'd0, rd);
`ifdef DMASND_LOOP_EN
        chk("loop_ctrl", rd, 16'h0003);
`else
        chk("loop_ctrl", rd, 16'h0001);
`endif
        n = 0;
        while (ev_q.size() == 0 && n < 100) begin
            @(negedge clk32); #2; n++;
        end
        reg_write(5'd9, 8'h28);
`ifdef DMASND_LOOP_EN
        n = 0;
        while (ev_q.size() < 3 && n < 100) begin
            @(negedge clk32); #2; n++;
        end
        reg_write(5'd0, 8'h01);
`endif
        wait_idle("loop_idle", 300);
        cmp_events("loop");

        // Empty frame with loop requested
        write24(5'd1, 24'h000100);
        write24(5'd7, 24'h000100);
        ev_q.delete(); exp_q.delete();
        model_frame(24'h000100, 24'h000100);
        reg_write(5'd0, 8'h03);
        wait_idle("empty_idle", 50);
        repeat (10) @(negedge clk32);
        cmp_events("empty");
        reg_read(5'd0, rd);
        chk("empty_ctrl", rd, 16'h0000);

        // Address wrap
        write24(5'd1, 24'hFFFFFE);
        write24(5'd7, 24'h000002);
        ev_q.delete(); exp_q.delete();
        model_frame(24'hFFFFFE, 24'h000002);
        reg_write(5'd0, 8'h01);
        wait_idle("wrap_idle", 200);
        cmp_events("wrap");

        // Randomized frames
        for (int it = 0; it < 8; it++) begin
            s = 24'($urandom) & 24'hFFFFFE;
            if (it == 3) s = 24'hFFFFFA;
            k = $urandom_range(1, 6);
            e = s + 24'(k * 2);
            dack_delay = $urandom_range(0, 3);
            sreq_rand  = 1'b1;
            write24(5'd1, s);
            write24(5'd7, e);
            ev_q.delete(); exp_q.delete();
            model_frame(s, e);
            reg_write(5'd0, 8'h01);
            wait_idle($sformatf("rnd%0d_idle", it), 1000);
            cmp_events($sformatf("rnd%0d", it));
            read24(5'd4, v);
            chk($sformatf("rnd%0d_cnt", it), v, e);
        end
        sreq_rand = 1'b0; sreq_force = 1'b1;

        // Abort in the grant cycle
        dack_en = 1'b0;
        @(negedge clk32);
        DACK = 1'b0;
        write24(5'd1, 24'h000400);
        write24(5'd7, 24'h000440);
        reg_write(5'd0, 8'h01);
        n = 0;
        while (DREQ !== 1'b1 && n < 20) begin
            @(negedge clk32); #2; n++;
        end
        chk("abort_dreq", DREQ, 1'b1);
        ev_q.delete();
        @(negedge clk32);
        CS = 1'b1; RW = 1'b0; A_s = 5'd0; DIN = 8'h00; DACK = 1'b1;
        @(posedge clk32);
        #1;
        CS = 1'b0; RW = 1'b1; DACK = 1'b0;
        chk("abort_sactive", SACTIVE, 1'b0);
        chk("abort_sload_n", SLOAD_N, 1'b1);
        chk("abort_dreq_low", DREQ, 1'b0);
        repeat (5) @(negedge clk32);
        #2;
        chk("abort_events", ev_q.size(), 0);
        read24(5'd4, v);
        chk("abort_cnt", v, 24'h000400);
        reg_read(5'd0, rd);
        chk("abort_ctrl", rd, 16'h0000);

        // Asynchronous reset in the middle of a request
        write24(5'd1, 24'h000500);
        write24(5'd7, 24'h000540);
        reg_write(5'd0, 8'h01);
        n = 0;
        while (DREQ !== 1'b1 && n < 20) begin
            @(negedge clk32); #2; n++;
        end
        chk("ares_dreq_before", DREQ, 1'b1);
        ev_q.delete();
        @(negedge clk32);
        #3 resb = 1'b0;
        #1;
        chk("ares_dreq",    DREQ,    1'b0);
        chk("ares_sactive", SACTIVE, 1'b0);
        chk("ares_sload_n", SLOAD_N, 1'b1);
        chk("ares_sint",    SINT,    1'b0);
        chk("ares_addr",    ADDR,    23'd0);
        @(negedge clk32);
        #2 resb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            reg_read(5'(i), rd);
            chk($sformatf("ares_reg%0d", i), rd, 16'd0);
        end
        chk("ares_events", ev_q.size(), 0);
        reg_write(5'd1, 8'h12);
        reg_read(5'd1, rd);
        chk("ares_first_write", rd, 16'h0012);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_snd_ctrl.md
DMA_SND_CTRL -- requirements
Module: dma_snd_ctrl

Interface
REQ-001 clk32  in  1  system clock; all state changes on its rising edge.
REQ-002 resb  in  1  reset, asynchronous, active-low.
REQ-003 CS  in  1  register chip select (sound register window).
REQ-004 A  in  5  word index A[5:1]:
- 0 = control
- 1/2/3 = frame start hi/mid/lo
- 4/5/6 = frame counter hi/mid/lo, read-only
- 7/8/9 = frame end hi/mid/lo
REQ-005 RW  in  1  1 = read, 0 = write.
REQ-006 DIN  in  8  register write data.
REQ-007 DOUT  out  16  register read data; upper byte always 0; 0 when not (CS&&RW) or when index is 10..31.
REQ-008 SREQ  in  1  sound FIFO not full, from the shifter.
REQ-009 DREQ  out  1  memory-slot request to the bus arbiter.
REQ-010 DACK  in  1  one-cycle grant pulse; sample word valid on MDIN for 2 cycles from DACK.
REQ-011 ADDR  out  23  word address [23:1] of the current fetch.
REQ-012 SLOAD_N  out  1  active-low load strobe to the shifter FIFO.
REQ-013 SINT  out  1  one-cycle frame-end pulse (MFP timer A).
REQ-014 SACTIVE  out  1  high while a frame is playing (MFP GPIP7).

Function
REQ-015 Control register layout:
- bit0 = enable
- bit1 = loop
- reads {6'b0, loop, enable}
REQ-016 Start and end are 24-bit values; the hi byte holds [23:16]; bit0 of the lo byte is written as 0 and reads 0.
REQ-017 FSM states: IDLE, ARM, REQ, LOAD, FEND.
REQ-018 IDLE: entered when enable is 0. DREQ=0, SACTIVE=0, SLOAD_N=1.
REQ-019 IDLE->ARM on the cycle after enable is written 1.
REQ-020 ARM (1 cycle) actions:
- copy start->counter, start->shadow_start, end->shadow_end
- set SACTIVE=1
- go to FEND if start==end, else to REQ.
REQ-021 REQ: DREQ = SREQ; ADDR = counter[23:1]; on DACK go to LOAD, DREQ=0 the following cycle.
REQ-022 LOAD (1 cycle):
- SLOAD_N=0 exactly this cycle, i.e. the cycle after DACK
- counter += 2, 24-bit, wrapping 0xFFFFFE->0x000000
- go to FEND if the new counter == shadow_end, else to REQ.
REQ-023 FEND (1 cycle): SINT=1.
REQ-024 FEND exit when loop=1 and shadow_start != shadow_end: go to ARM; new start/end register values are picked up there.
REQ-025 FEND exit otherwise: clear enable, SACTIVE=0, go to IDLE.
REQ-026 Writing start or end during a frame does not affect the running frame; the values take effect at the next ARM.
REQ-027 Writing enable=0 in any state: go to IDLE next cycle.
- A DACK in that same cycle produces no SLOAD_N and no counter update.
- No SINT is generated.
REQ-028 Writing enable=1 while already playing has no effect.
REQ-029 The counter readback returns the live counter; it holds its last value in IDLE.
REQ-030 Register read data is combinational; writes take effect on the clock edge where CS&&!RW.

Reset
REQ-031 On resb=0 the block immediately forces:
- FSM = IDLE
- DREQ=0, SLOAD_N=1, SINT=0, SACTIVE=0, ADDR=0
- control, start, end, counter and shadows all 0.
REQ-032 Reset mid-frame aborts the frame with no SLOAD_N or SINT pulse.
REQ-033 Leaving reset requires no sync cycles; the first write is honoured on the first clock edge after deassertion.

Configuration
REQ-034 Macro DMASND_LOOP_EN.
- Defined: the loop bit is writable and REQ-024 applies.
- Undefined: the loop bit is not writable and reads 0; every frame ends per REQ-025.

Verification
REQ-035 Single frame:
- Stimulus: start=0x010000, end=0x010006, loop=0, enable=1, SREQ=1, DACK 3 cycles after each DREQ.
- Response: 3 SLOAD_N pulses with ADDR=0x008000/0x008001/0x008002, then one SINT, then SACTIVE=0 and control reads 0x00.
REQ-036 FIFO backpressure:
- Stimulus: SREQ=0 for 50 cycles after ARM.
- Response: DREQ stays 0 and no SLOAD_N; DREQ rises the cycle SREQ rises.
REQ-037 Loop with shadowing (DMASND_LOOP_EN):
- Stimulus: start=0x20, end=0x24, loop=1, enable=1; write end=0x28 mid-frame.
- Response: first frame makes 2 loads and SINT; second frame makes 4 loads from 0x20.
REQ-038 Abort:
- Stimulus: enable=0 written in the cycle DACK arrives.
- Response: no SLOAD_N, no SINT, IDLE next cycle, counter unchanged.
REQ-039 Empty frame and wrap:
- Stimulus A: start=end=0x100 with loop=1.
- Response A: exactly one SINT, then IDLE.
- Stimulus B: start=0xFFFFFE, end=0x000002.
- Response B: loads at ADDR 0x7FFFFF then 0x000000, then SINT.
REQ-040 Async reset:
- Stimulus: resb pulsed low mid-REQ, not aligned to a clock edge.
- Response: outputs reach reset values before the next edge; registers read 0.
